// File: rtl/axi_isolate_seq.sv
// Isolation sequencer: applies masked isolate/release commands to a bank of AXI
// isolators, waits for their status to follow, and answers each command once.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a command; isolate_o holds the last commanded value
// WAIT  | command applied; waiting for isolated_i or the timeout budget
// RESP  | response presented until rsp_ready_i
module axi_isolate_seq #(
  parameter int unsigned NumPorts      = 4,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_isolate_i,
  input  logic [NumPorts-1:0] req_mask_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic                rsp_timeout_o,
  output logic [NumPorts-1:0] rsp_fail_mask_o,
  output logic [NumPorts-1:0] isolate_o,
  input  logic [NumPorts-1:0] isolated_i,
  output logic                busy_o
);

  localparam int unsigned CntW = (TimeoutCycles == 0) ? 1 : $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntLast = (TimeoutCycles == 0) ? '0 : CntW'(TimeoutCycles - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t              state_q;
  logic [NumPorts-1:0] isolate_q;
  logic                op_q;
  logic [NumPorts-1:0] mask_q;
  logic [CntW-1:0]     cnt_q;
  logic [NumPorts-1:0] fail_q;
  logic                timeout_q;

  logic                done;
  logic                timeout_hit;
  logic [NumPorts-1:0] mismatch;

  // Ports in the mask that have not yet followed the command.
  assign mismatch    = op_q ? (mask_q & ~isolated_i) : (mask_q & isolated_i);
  assign done        = (mismatch == '0);
  assign timeout_hit = (TimeoutCycles != 0) && (cnt_q == CntLast);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      isolate_q <= '1;
      op_q      <= 1'b0;
      mask_q    <= '0;
      cnt_q     <= '0;
      fail_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            op_q      <= req_isolate_i;
            mask_q    <= req_mask_i;
            cnt_q     <= '0;
            isolate_q <= req_isolate_i ? (isolate_q | req_mask_i)
                                       : (isolate_q & ~req_mask_i);
            state_q   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (done) begin
            fail_q    <= '0;
            timeout_q <= 1'b0;
            state_q   <= ST_RESP;
          end else if (timeout_hit) begin
            fail_q    <= mismatch;
            timeout_q <= 1'b1;
            state_q   <= ST_RESP;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            fail_q    <= '0;
            timeout_q <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o     = (state_q == ST_IDLE);
  assign rsp_valid_o     = (state_q == ST_RESP);
  assign busy_o          = (state_q != ST_IDLE);
  assign rsp_timeout_o   = timeout_q;
  assign rsp_fail_mask_o = fail_q;
  assign isolate_o       = isolate_q;

endmodule
